// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage -- ID stage of a 16-bit, 16-register pipeline.
//
// Decodes the IF/ID instruction, reads the register file (write-back bypass
// included), detects load-use / flag / branch-register hazards, resolves
// B/BR branches combinationally and registers the decoded fields into ID/EX.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   enable                   downstream advance (0 holds ID/EX, masks stall)
//   curr_pc_fd, next_pc_fd   IF/ID program counters
//   curr_instr_fd            IF/ID instruction word
//   flags_curr               {Z,V,N} from the flag register
//   ex_dst/ex_reg_wr/ex_mem_rd/ex_sets_flags  instruction currently in EX
//   wb_wr_en/wb_dst/wb_data  register write-back port
//   stall, branch_taken, branch_target        combinational from IF/ID
//   *_de                     registered ID/EX payload
//
// Fields an opcode does not use are driven as zero in ID/EX: rs/rt data of
// registers that are not read, imm of opcodes without an immediate, and
// dst_de of opcodes that never write a register (SW, B, BR, HLT).
// ---------------------------------------------------------------------------
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] curr_pc_fd,
    input  logic [15:0] next_pc_fd,
    input  logic [15:0] curr_instr_fd,
    input  logic [2:0]  flags_curr,
    input  logic [3:0]  ex_dst,
    input  logic        ex_reg_wr,
    input  logic        ex_mem_rd,
    input  logic        ex_sets_flags,
    input  logic        wb_wr_en,
    input  logic [3:0]  wb_dst,
    input  logic [15:0] wb_data,
    output logic        stall,
    output logic        branch_taken,
    output logic [15:0] branch_target,
    output logic [15:0] rs_data_de,
    output logic [15:0] rt_data_de,
    output logic [15:0] imm_de,
    output logic [15:0] next_pc_de,
    output logic [3:0]  opcode_de,
    output logic [3:0]  dst_de,
    output logic        reg_wr_de,
    output logic        mem_rd_de,
    output logic        mem_wr_de,
    output logic        halt_de
);

    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 4;
    localparam int unsigned NREG = 16;

    localparam logic [3:0] OP_SLL = 4'h4;
    localparam logic [3:0] OP_SRA = 4'h5;
    localparam logic [3:0] OP_ROR = 4'h6;
    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_LLB = 4'hA;
    localparam logic [3:0] OP_LHB = 4'hB;
    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_BR  = 4'hD;
    localparam logic [3:0] OP_PCS = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Current PC is carried in IF/ID for other stages; decode has no use for it.
    logic unused_c;
    assign unused_c = ^curr_pc_fd;

    // Instruction fields
    logic [3:0] op;
    logic [3:0] f_a;
    logic [3:0] f_b;
    logic [3:0] f_c;
    logic [2:0] cond;
    assign op   = curr_instr_fd[15:12];
    assign f_a  = curr_instr_fd[11:8];
    assign f_b  = curr_instr_fd[7:4];
    assign f_c  = curr_instr_fd[3:0];
    assign cond = curr_instr_fd[11:9];

    // Register file; R0 is never written so it stays zero after reset.
    logic [DW-1:0] rf_q [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_wr_en && (wb_dst != '0)) begin
            rf_q[wb_dst] <= wb_data;
        end
    end

    // Field selection per opcode.
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic          rs_used;
    logic          rt_used;
    logic          rs_is_pc;
    logic [AW-1:0] dst_dec;
    logic [DW-1:0] imm_dec;
    logic          wr_op;

    always_comb begin
        rs_addr  = f_b;
        rt_addr  = f_c;
        rs_used  = 1'b0;
        rt_used  = 1'b0;
        rs_is_pc = 1'b0;
        dst_dec  = '0;
        imm_dec  = '0;
        wr_op    = 1'b0;
        case (op)
            OP_SLL, OP_SRA, OP_ROR: begin
                rs_used = 1'b1;
                dst_dec = f_a;
                imm_dec = DW'(f_c);
                wr_op   = 1'b1;
            end
            OP_LW: begin
                rs_used = 1'b1;
                dst_dec = f_a;
                imm_dec = {{11{f_c[3]}}, f_c, 1'b0};
                wr_op   = 1'b1;
            end
            OP_SW: begin
                rs_used = 1'b1;
                rt_used = 1'b1;
                rt_addr = f_a;
                imm_dec = {{11{f_c[3]}}, f_c, 1'b0};
            end
            OP_LLB, OP_LHB: begin
                rs_used = 1'b1;
                rs_addr = f_a;
                dst_dec = f_a;
                imm_dec = DW'(curr_instr_fd[7:0]);
                wr_op   = 1'b1;
            end
            OP_B: begin
            end
            OP_BR: begin
                rs_used = 1'b1;
            end
            OP_PCS: begin
                rs_is_pc = 1'b1;
                dst_dec  = f_a;
                wr_op    = 1'b1;
            end
            OP_HLT: begin
            end
            default: begin
                // ADD, SUB, XOR, RED, PADDSB: three-register format
                rs_used = 1'b1;
                rt_used = 1'b1;
                dst_dec = f_a;
                wr_op   = 1'b1;
            end
        endcase
    end

    // Register reads with write-back bypass; R0 always reads zero.
    logic [DW-1:0] rs_rd;
    logic [DW-1:0] rt_rd;

    always_comb begin
        rs_rd = rf_q[rs_addr];
        rt_rd = rf_q[rt_addr];
        if (wb_wr_en && (wb_dst == rs_addr)) rs_rd = wb_data;
        if (wb_wr_en && (wb_dst == rt_addr)) rt_rd = wb_data;
        if (rs_addr == '0) rs_rd = '0;
        if (rt_addr == '0) rt_rd = '0;
    end

    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;
    assign rs_val = rs_is_pc ? next_pc_fd : (rs_used ? rs_rd : '0);
    assign rt_val = rt_used ? rt_rd : '0;

    // Branch condition evaluation on {Z,V,N}.
    logic flag_z;
    logic flag_v;
    logic flag_n;
    logic cond_true;
    assign flag_z = flags_curr[2];
    assign flag_v = flags_curr[1];
    assign flag_n = flags_curr[0];

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            3'b000:  cond_true = !flag_z;
            3'b001:  cond_true = flag_z;
            3'b010:  cond_true = !flag_z && !flag_n;
            3'b011:  cond_true = flag_n;
            3'b100:  cond_true = flag_z || (!flag_z && !flag_n);
            3'b101:  cond_true = flag_n || flag_z;
            3'b110:  cond_true = flag_v;
            default: cond_true = 1'b1;
        endcase
    end

    // Hazard detection.
    logic is_b;
    logic is_br;
    logic load_use;
    logic flag_haz;
    logic br_haz;
    assign is_b  = (op == OP_B);
    assign is_br = (op == OP_BR);

    assign load_use = ex_mem_rd && (ex_dst != '0) &&
                      ((rs_used && (rs_addr == ex_dst)) ||
                       (rt_used && (rt_addr == ex_dst)));
    assign flag_haz = (is_b || is_br) && (cond != 3'b111) && ex_sets_flags;
    assign br_haz   = is_br && ex_reg_wr && (ex_dst == f_b) && (ex_dst != '0);

    // A held downstream already freezes the front end, so stall is masked.
    assign stall = enable && (load_use || flag_haz || br_haz);

    assign branch_taken  = (is_b || is_br) && cond_true && !stall;
    assign branch_target = is_br ? rs_rd
                                 : DW'(next_pc_fd + {{6{curr_instr_fd[8]}}, curr_instr_fd[8:0], 1'b0});

    // ID/EX pipeline register.
    logic [DW-1:0] rs_data_q, rs_data_d;
    logic [DW-1:0] rt_data_q, rt_data_d;
    logic [DW-1:0] imm_q,     imm_d;
    logic [DW-1:0] npc_q,     npc_d;
    logic [3:0]    opcode_q,  opcode_d;
    logic [AW-1:0] dst_q,     dst_d;
    logic          reg_wr_q,  reg_wr_d;
    logic          mem_rd_q,  mem_rd_d;
    logic          mem_wr_q,  mem_wr_d;
    logic          halt_q,    halt_d;

    always_comb begin
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        npc_d     = npc_q;
        opcode_d  = opcode_q;
        dst_d     = dst_q;
        reg_wr_d  = reg_wr_q;
        mem_rd_d  = mem_rd_q;
        mem_wr_d  = mem_wr_q;
        halt_d    = halt_q;
        if (enable) begin
            if (stall) begin
                rs_data_d = '0;
                rt_data_d = '0;
                imm_d     = '0;
                npc_d     = '0;
                opcode_d  = '0;
                dst_d     = '0;
                reg_wr_d  = 1'b0;
                mem_rd_d  = 1'b0;
                mem_wr_d  = 1'b0;
                halt_d    = 1'b0;
            end else begin
                rs_data_d = rs_val;
                rt_data_d = rt_val;
                imm_d     = imm_dec;
                npc_d     = next_pc_fd;
                opcode_d  = op;
                dst_d     = dst_dec;
                reg_wr_d  = wr_op && (dst_dec != '0);
                mem_rd_d  = (op == OP_LW);
                mem_wr_d  = (op == OP_SW);
                halt_d    = (op == OP_HLT);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            npc_q     <= '0;
            opcode_q  <= '0;
            dst_q     <= '0;
            reg_wr_q  <= 1'b0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            npc_q     <= npc_d;
            opcode_q  <= opcode_d;
            dst_q     <= dst_d;
            reg_wr_q  <= reg_wr_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            halt_q    <= halt_d;
        end
    end

    assign rs_data_de = rs_data_q;
    assign rt_data_de = rt_data_q;
    assign imm_de     = imm_q;
    assign next_pc_de = npc_q;
    assign opcode_de  = opcode_q;
    assign dst_de     = dst_q;
    assign reg_wr_de  = reg_wr_q;
    assign mem_rd_de  = mem_rd_q;
    assign mem_wr_de  = mem_wr_q;
    assign halt_de    = halt_q;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage -- self-checking bench for decode_stage: directed scenarios
// plus a randomized run against a behavioural reference model.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] curr_pc_fd;
    logic [15:0] next_pc_fd;
    logic [15:0] curr_instr_fd;
    logic [2:0]  flags_curr;
    logic [3:0]  ex_dst;
    logic        ex_reg_wr;
    logic        ex_mem_rd;
    logic        ex_sets_flags;
    logic        wb_wr_en;
    logic [3:0]  wb_dst;
    logic [15:0] wb_data;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] rs_data_de;
    logic [15:0] rt_data_de;
    logic [15:0] imm_de;
    logic [15:0] next_pc_de;
    logic [3:0]  opcode_de;
    logic [3:0]  dst_de;
    logic        reg_wr_de;
    logic        mem_rd_de;
    logic        mem_wr_de;
    logic        halt_de;

    decode_stage dut (
        .clk(clk), .rst(rst), .enable(enable),
        .curr_pc_fd(curr_pc_fd), .next_pc_fd(next_pc_fd), .curr_instr_fd(curr_instr_fd),
        .flags_curr(flags_curr), .ex_dst(ex_dst), .ex_reg_wr(ex_reg_wr),
        .ex_mem_rd(ex_mem_rd), .ex_sets_flags(ex_sets_flags),
        .wb_wr_en(wb_wr_en), .wb_dst(wb_dst), .wb_data(wb_data),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .rs_data_de(rs_data_de), .rt_data_de(rt_data_de), .imm_de(imm_de),
        .next_pc_de(next_pc_de), .opcode_de(opcode_de), .dst_de(dst_de),
        .reg_wr_de(reg_wr_de), .mem_rd_de(mem_rd_de), .mem_wr_de(mem_wr_de),
        .halt_de(halt_de)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] rs;
        logic [15:0] rt;
        logic [15:0] imm;
        logic [15:0] npc;
        logic [3:0]  op;
        logic [3:0]  dst;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        hlt;
    } idex_t;

    idex_t got;
    assign got = {rs_data_de, rt_data_de, imm_de, next_pc_de, opcode_de, dst_de,
                  reg_wr_de, mem_rd_de, mem_wr_de, halt_de};

    logic [15:0] regs [16];
    int errors = 0;
    int checks = 0;

    // Architectural register read as seen by decode this cycle.
    function automatic logic [15:0] rd(input logic [3:0] r);
        if (r == 4'd0) return 16'h0000;
        if (wb_wr_en && wb_dst == r) return wb_data;
        return regs[r];
    endfunction

    function automatic idex_t decode_ref(input logic [15:0] ins, input logic [15:0] npc);
        idex_t e;
        logic [3:0] a, b, c;
        int s;
        e = '0;
        a = ins[11:8];
        b = ins[7:4];
        c = ins[3:0];
        s = (c >= 4'd8) ? int'(c) - 16 : int'(c);
        e.op  = ins[15:12];
        e.npc = npc;
        case (ins[15:12])
            4'h0, 4'h1, 4'h2, 4'h3, 4'h7: begin e.dst = a; e.rs = rd(b); e.rt = rd(c); end
            4'h4, 4'h5, 4'h6:             begin e.dst = a; e.rs = rd(b); e.imm = 16'(c); end
            4'h8: begin e.dst = a; e.rs = rd(b); e.imm = 16'(s * 2); e.mr = 1'b1; end
            4'h9: begin e.rs = rd(b); e.rt = rd(a); e.imm = 16'(s * 2); e.mw = 1'b1; end
            4'hA, 4'hB: begin e.dst = a; e.rs = rd(a); e.imm = 16'(ins[7:0]); end
            4'hD: e.rs = rd(b);
            4'hE: begin e.dst = a; e.rs = npc; end
            4'hF: e.hlt = 1'b1;
            default: ;
        endcase
        e.rw = (ins[15:12] <= 4'h8 || ins[15:12] == 4'hA || ins[15:12] == 4'hB ||
                ins[15:12] == 4'hE) && (e.dst != 4'd0);
        return e;
    endfunction

    // Does the instruction architecturally read register r?
    function automatic bit reads_reg(input logic [15:0] ins, input logic [3:0] r);
        case (ins[15:12])
            4'h0, 4'h1, 4'h2, 4'h3, 4'h7: return (ins[7:4] == r) || (ins[3:0] == r);
            4'h4, 4'h5, 4'h6, 4'h8, 4'hD:  return ins[7:4] == r;
            4'h9:                         return (ins[7:4] == r) || (ins[11:8] == r);
            4'hA, 4'hB:                   return ins[11:8] == r;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic bit cond_ref(input logic [2:0] cc, input logic [2:0] f);
        bit z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (cc)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit stall_ref();
        bit is_br, is_bx;
        is_br = curr_instr_fd[15:12] == 4'hD;
        is_bx = is_br || curr_instr_fd[15:12] == 4'hC;
        if (!enable) return 1'b0;
        if (ex_mem_rd && ex_dst != 4'd0 && reads_reg(curr_instr_fd, ex_dst)) return 1'b1;
        if (is_bx && curr_instr_fd[11:9] != 3'b111 && ex_sets_flags) return 1'b1;
        if (is_br && ex_reg_wr && ex_dst == curr_instr_fd[7:4] && ex_dst != 4'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] target_ref();
        int o;
        if (curr_instr_fd[15:12] == 4'hD) return rd(curr_instr_fd[7:4]);
        o = int'(curr_instr_fd[8:0]);
        if (o >= 256) o = o - 512;
        return 16'(int'(next_pc_fd) + 2 * o);
    endfunction

    // Advance one clock, mirror the architectural register writes, settle.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
        end else if (wb_wr_en && wb_dst != 4'd0) begin
            regs[wb_dst] = wb_data;
        end
        #1;
    endtask

    task automatic quiet();
        enable = 1'b1; ex_dst = 4'd0; ex_reg_wr = 1'b0; ex_mem_rd = 1'b0;
        ex_sets_flags = 1'b0; wb_wr_en = 1'b0; wb_dst = 4'd0; wb_data = 16'h0;
        flags_curr = 3'b000;
    endtask

    task automatic wb_write(input logic [3:0] r, input logic [15:0] v);
        wb_wr_en = 1'b1; wb_dst = r; wb_data = v;
        tick();
        wb_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; quiet();
        curr_instr_fd = 16'hF000; next_pc_fd = 16'h1234; curr_pc_fd = 16'h1232;
        tick(); tick();
        checks++;
        if (got !== idex_t'(0)) begin
            errors++; $display("FAIL reset_idex got=%h exp=0", got);
        end
        rst = 1'b0;
        curr_instr_fd = 16'h0000; next_pc_fd = 16'h0002;
        #1;
        checks++;
        if (stall !== 1'b0 || branch_taken !== 1'b0) begin
            errors++; $display("FAIL reset_comb stall=%b bt=%b exp=0/0", stall, branch_taken);
        end
        tick();
        checks++;
        if (got !== idex_t'({64'h0, 16'h0002, 12'h0})) begin
            errors++; $display("FAIL nop_decode got=%h exp npc=0002 rest 0", got);
        end
    endtask

    task automatic test_bypass();
        idex_t e;
        quiet();
        wb_write(4'd5, 16'h5555);
        curr_instr_fd = 16'h0435; next_pc_fd = 16'h0100;
        wb_wr_en = 1'b1; wb_dst = 4'd3; wb_data = 16'h1234;
        #1;
        e = decode_ref(curr_instr_fd, next_pc_fd);
        tick();
        wb_wr_en = 1'b0;
        checks++;
        if (rs_data_de !== 16'h1234) begin
            errors++; $display("FAIL bypass_rs got=%h exp=1234", rs_data_de);
        end
        checks++;
        if (got !== e || rt_data_de !== 16'h5555 || dst_de !== 4'd4 || reg_wr_de !== 1'b1) begin
            errors++; $display("FAIL bypass_idex got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_load_use();
        quiet();
        wb_write(4'd2, 16'h2222);
        wb_write(4'd3, 16'h3333);
        curr_instr_fd = 16'h1123; next_pc_fd = 16'h0200;
        ex_mem_rd = 1'b1; ex_dst = 4'd2;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL load_use_stall got=%b exp=1", stall);
        end
        tick();
        checks++;
        if (got !== idex_t'(0)) begin
            errors++; $display("FAIL load_use_bubble got=%h exp=0", got);
        end
        ex_mem_rd = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL load_use_release got=%b exp=0", stall);
        end
        tick();
        checks++;
        if (got !== idex_t'({16'h2222, 16'h3333, 16'h0, 16'h0200, 4'h1, 4'h1, 4'b1000})) begin
            errors++; $display("FAIL load_use_load got=%h", got);
        end
    endtask

    task automatic test_branch();
        quiet();
        curr_instr_fd = 16'hC3FE; next_pc_fd = 16'h0010;
        flags_curr = 3'b100;
        #1;
        checks++;
        if (branch_taken !== 1'b1 || branch_target !== 16'h000C) begin
            errors++; $display("FAIL b_taken bt=%b tgt=%h exp=1/000C", branch_taken, branch_target);
        end
        flags_curr = 3'b000;
        #1;
        checks++;
        if (branch_taken !== 1'b0) begin
            errors++; $display("FAIL b_not_taken bt=%b exp=0", branch_taken);
        end
        flags_curr = 3'b100; ex_sets_flags = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1 || branch_taken !== 1'b0) begin
            errors++; $display("FAIL b_flag_stall stall=%b bt=%b exp=1/0", stall, branch_taken);
        end
        tick();
    endtask

    task automatic test_br_stall();
        quiet();
        wb_write(4'd7, 16'h0400);
        curr_instr_fd = 16'hDE70; next_pc_fd = 16'h0300;
        ex_reg_wr = 1'b1; ex_dst = 4'd7; ex_sets_flags = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1 || branch_taken !== 1'b0) begin
            errors++; $display("FAIL br_stall stall=%b bt=%b exp=1/0", stall, branch_taken);
        end
        tick();
        checks++;
        if (got !== idex_t'(0)) begin
            errors++; $display("FAIL br_bubble got=%h exp=0", got);
        end
        ex_reg_wr = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || branch_taken !== 1'b1 || branch_target !== 16'h0400) begin
            errors++; $display("FAIL br_taken stall=%b bt=%b tgt=%h exp=0/1/0400",
                               stall, branch_taken, branch_target);
        end
        tick();
        checks++;
        if (got !== idex_t'({16'h0400, 32'h0, 16'h0300, 4'hD, 4'h0, 4'b0000})) begin
            errors++; $display("FAIL br_idex got=%h", got);
        end
    endtask

    task automatic test_enable_hold();
        idex_t held;
        quiet();
        curr_instr_fd = 16'hF000; next_pc_fd = 16'h0444;
        tick();
        held = decode_ref(16'hF000, 16'h0444);
        checks++;
        if (got !== held || halt_de !== 1'b1 || reg_wr_de !== 1'b0) begin
            errors++; $display("FAIL hlt_decode got=%h exp=%h", got, held);
        end
        enable = 1'b0;
        curr_instr_fd = 16'h1123; ex_mem_rd = 1'b1; ex_dst = 4'd2;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL hold_stall_mask got=%b exp=0", stall);
        end
        tick();
        checks++;
        if (got !== held) begin
            errors++; $display("FAIL hold_idex got=%h exp=%h", got, held);
        end
    endtask

    task automatic test_r0_and_reset();
        quiet();
        wb_write(4'd0, 16'hFFFF);
        curr_instr_fd = 16'h0100; next_pc_fd = 16'h0050;
        wb_wr_en = 1'b1; wb_dst = 4'd0; wb_data = 16'hFFFF;
        tick();
        wb_wr_en = 1'b0;
        checks++;
        if (rs_data_de !== 16'h0000 || rt_data_de !== 16'h0000) begin
            errors++; $display("FAIL r0_read rs=%h rt=%h exp=0000", rs_data_de, rt_data_de);
        end
        for (int i = 1; i < 16; i++) wb_write(4'(i), 16'(16'hA000 + i));
        curr_instr_fd = 16'h8123; next_pc_fd = 16'h0060;
        tick();
        rst = 1'b1; enable = 1'b0; ex_mem_rd = 1'b1; ex_dst = 4'd2;
        tick();
        rst = 1'b0; quiet();
        checks++;
        if (got !== idex_t'(0)) begin
            errors++; $display("FAIL midrst_idex got=%h exp=0", got);
        end
        for (int i = 0; i < 16; i += 2) begin
            curr_instr_fd = {4'h0, 4'h1, 4'(i), 4'(i + 1)};
            tick();
            checks++;
            if (rs_data_de !== 16'h0 || rt_data_de !== 16'h0) begin
                errors++; $display("FAIL midrst_regs r%0d rs=%h rt=%h exp=0000",
                                   i, rs_data_de, rt_data_de);
            end
        end
    endtask

    task automatic test_random();
        idex_t exp_q, dec;
        bit    s_exp, bt_exp;
        bit    is_bx;
        rst = 1'b1; quiet();
        tick();
        rst = 1'b0;
        exp_q = '0;
        for (int n = 0; n < 400; n++) begin
            curr_instr_fd = 16'($urandom);
            next_pc_fd    = 16'($urandom);
            curr_pc_fd    = 16'(next_pc_fd - 16'd2);
            flags_curr    = 3'($urandom);
            ex_dst        = 4'($urandom);
            ex_reg_wr     = 1'($urandom);
            ex_mem_rd     = ($urandom % 4) == 0;
            ex_sets_flags = ($urandom % 3) == 0;
            wb_wr_en      = 1'($urandom);
            wb_dst        = 4'($urandom);
            wb_data       = 16'($urandom);
            enable        = ($urandom % 8) != 0;
            #1;
            s_exp  = stall_ref();
            is_bx  = curr_instr_fd[15:12] == 4'hC || curr_instr_fd[15:12] == 4'hD;
            bt_exp = is_bx && cond_ref(curr_instr_fd[11:9], flags_curr) && !s_exp;
            dec    = decode_ref(curr_instr_fd, next_pc_fd);
            checks++;
            if (stall !== s_exp || branch_taken !== bt_exp) begin
                errors++; $display("FAIL rand_comb n=%0d ins=%h stall=%b/%b bt=%b/%b",
                                   n, curr_instr_fd, stall, s_exp, branch_taken, bt_exp);
            end
            if (is_bx) begin
                checks++;
                if (branch_target !== target_ref()) begin
                    errors++; $display("FAIL rand_target n=%0d ins=%h got=%h exp=%h",
                                       n, curr_instr_fd, branch_target, target_ref());
                end
            end
            if (enable) exp_q = s_exp ? idex_t'(0) : dec;
            tick();
            checks++;
            if (got !== exp_q) begin
                errors++; $display("FAIL rand_idex n=%0d got=%h exp=%h", n, got, exp_q);
            end
        end
    endtask

    initial begin
        rst = 1'b1; quiet();
        curr_pc_fd = 16'h0; next_pc_fd = 16'h0; curr_instr_fd = 16'h0;
        for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
        #2;
        test_reset();
        test_bypass();
        test_load_use();
        test_branch();
        test_br_stall();
        test_enable_hold();
        test_r0_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have no parameters; data width fixed at 16 bits, 16 architectural registers.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: enable  in  1  downstream advance (0 = hold ID/EX); curr_pc_fd, next_pc_fd, curr_instr_fd  in  16  IF/ID contents.
REQ-004 SHALL have ports: flags_curr  in  3  {Z,V,N} from flag register; ex_dst  in  4, ex_reg_wr  in  1, ex_mem_rd  in  1, ex_sets_flags  in  1  instruction now in EX.
REQ-005 SHALL have ports: wb_wr_en  in  1, wb_dst  in  4, wb_data  in  16  register write-back.
REQ-006 SHALL have ports: stall  out  1  hold fetch/IF-ID; branch_taken  out  1; branch_target  out  16; both combinational from IF/ID contents.
REQ-007 SHALL have registered ID/EX ports: rs_data_de, rt_data_de, imm_de, next_pc_de  out  16; opcode_de  out  4; dst_de  out  4; reg_wr_de, mem_rd_de, mem_wr_de, halt_de  out  1.

Function
REQ-008 Opcode = instr[15:12]: 0 ADD,1 SUB,2 XOR,3 RED,4 SLL,5 SRA,6 ROR,7 PADDSB,8 LW,9 SW,A LLB,B LHB,C B,D BR,E PCS,F HLT.
REQ-009 Field map: ALU ops 0-3,7: dst [11:8], rs [7:4], rt [3:0]; 4-6: dst [11:8], rs [7:4], imm_de = zero-ext [3:0], rt not read.
REQ-010 LW/SW: base rs [7:4], rt/dst [11:8], imm_de = sign-ext([3:0]) << 1; SW reads rt [11:8], no write.
REQ-011 LLB/LHB: dst and rs = [11:8], imm_de = zero-ext [7:0]; PCS: dst [11:8], rs_data_de = next_pc_fd.
REQ-012 reg_wr_de = 1 for opcodes 0-8, A, B, E, and 0 whenever dst = 0; mem_rd_de = LW; mem_wr_de = SW; halt_de = HLT.
REQ-013 Register file: 16x16; R0 reads 0 and ignores writes; write at posedge when wb_wr_en; same-cycle read of wb_dst returns wb_data (bypass).
REQ-014 Condition [11:9]: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
REQ-015 branch_taken = (B or BR) & condition true & !stall; branch_target: B = next_pc_fd + (sign-ext([8:0]) << 1) mod 2^16; BR = register [7:4].
REQ-016 Load-use stall: ex_mem_rd & ex_dst != 0 & ex_dst equals any register actually read -> stall = 1.
REQ-017 Flag stall: conditional B/BR (cond != 111) & ex_sets_flags -> stall = 1.
REQ-018 BR register stall: BR & ex_reg_wr & ex_dst = [7:4] & ex_dst != 0 -> stall = 1.
REQ-019 stall is forced 0 when enable = 0 (downstream hold owns the pipeline).
REQ-020 ID/EX update priority at posedge: rst -> clear; else enable = 0 -> hold; else stall = 1 -> bubble; else load decoded values.
REQ-021 Bubble = all ID/EX outputs 0 (reg_wr/mem/halt deasserted); latency IF/ID -> ID/EX one cycle.
REQ-022 An all-zero instruction word (reset IF/ID) decodes as ADD R0,R0,R0 with reg_wr_de = 0: harmless NOP.
REQ-023 HLT decoded under branch_taken = 0 is passed with halt_de = 1; B/BR/HLT produce reg_wr_de = 0.

Reset
REQ-024 rst clears all 16 registers and every ID/EX output to 0 on the next posedge.
REQ-025 Reset asserted mid-stall overrides stall and enable; first cycle after reset: stall = 0 unless REQ-016-018 hold.

Verification
REQ-026 wb write R3 = 0x1234 in the same cycle ADD R4,R3,R5 (0x0435) is decoded -> rs_data_de = 0x1234 next cycle.
REQ-027 ex_mem_rd = 1, ex_dst = 2, instr SUB R1,R2,R3 (0x1123) -> stall = 1, next ID/EX all 0; ex_mem_rd drops -> normal load.
REQ-028 B cond 001 imm 0x1FE, next_pc_fd 0x0010, Z = 1, no stall -> branch_taken = 1, target 0x000C; with Z = 0 -> branch_taken = 0.
REQ-029 BR cond 111, R7 = 0x0400, ex_reg_wr = 1, ex_dst = 7 -> stall = 1, branch_taken = 0; next cycle no hazard -> target 0x0400.
REQ-030 Write R0 = 0xFFFF then read R0 -> 0x0000; rst mid-operation -> all registers and outputs 0 next cycle.
